// File: rtl/instruction_fetch_unit.sv
// PC + IF/ID register feeding Memory_System; one-edge fetch latency, stall_i holds PC and IF/ID.
// Optional saturating perf counters are built when FETCH_PERF_CNT_EN is defined.
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h00400000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] target_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  valid_o,
  output logic                  fault_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [DATA_WIDTH-1:0] fetch_count_o,
  output logic [DATA_WIDTH-1:0] stall_count_o
`endif
);

  typedef enum logic [0:0] {FETCH = 1'b0, FAULT = 1'b1} state_t;

  // One extra bit so the window end and pc+4 are compared without wrapping.
  localparam int             AW       = DATA_WIDTH + 1;
  localparam logic [AW-1:0]  ROM_BASE = AW'(RESET_PC);
  localparam logic [AW-1:0]  ROM_END  = ROM_BASE + AW'(4 * MEMORY_DEPTH);

  function automatic logic in_window(input logic [AW-1:0] a);
    return (a >= ROM_BASE) && (a < ROM_END) && (a[1:0] == 2'b00);
  endfunction

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
  logic                  valid_q, valid_d;
  logic                  adv;
  logic                  stall_hold;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    adv        = 1'b0;
    stall_hold = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect_i) begin
          // Either way the wrong-path instruction in IF/ID is squashed.
          valid_d = 1'b0;
          if (in_window({1'b0, target_i})) pc_d    = target_i;
          else                             state_d = FAULT;
        end else if (stall_i) begin
          stall_hold = 1'b1;
        end else begin
          adv     = 1'b1;
          instr_d = instr_i;
          pc4_d   = pc_q + DATA_WIDTH'(4);
          valid_d = 1'b1;
          // Running off the ROM end still delivers the last legal instruction.
          if (in_window({1'b0, pc_q} + AW'(4))) pc_d    = pc_q + DATA_WIDTH'(4);
          else                                  state_d = FAULT;
        end
      end
      FAULT:   valid_d = 1'b0;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o       = pc_q;
  assign instr_o    = instr_q;
  assign pc_plus4_o = pc4_q;
  assign valid_o    = valid_q;
  assign fault_o    = (state_q == FAULT);

`ifdef FETCH_PERF_CNT_EN
  logic [DATA_WIDTH-1:0] fetch_cnt_q;
  logic [DATA_WIDTH-1:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (state_q == FETCH) begin
      if (adv && (fetch_cnt_q != '1))
        fetch_cnt_q <= fetch_cnt_q + 1'b1;
      if (stall_hold && valid_q && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign fetch_count_o = fetch_cnt_q;
  assign stall_count_o = stall_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = adv ^ stall_hold;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit against a behavioural fetch model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] BASE  = 32'h00400000;
  localparam int          DEPTH = 64;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0, stall_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] target_i = '0;
  logic [31:0] instr_i;
  logic [31:0] pc_o, instr_o, pc_plus4_o;
  logic        valid_o, fault_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_o, stall_count_o;
`endif

  instruction_fetch_unit dut (
    .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .target_i(target_i), .instr_i(instr_i), .pc_o(pc_o), .instr_o(instr_o),
    .pc_plus4_o(pc_plus4_o), .valid_o(valid_o), .fault_o(fault_o)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count_o(fetch_count_o), .stall_count_o(stall_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Memory_System ROM: combinational read of the presented address.
  logic [31:0] rom [DEPTH];
  always_comb begin
    longint unsigned off;
    off = longint'(pc_o) - longint'(BASE);
    if (pc_o >= BASE && off < 4 * DEPTH) instr_i = rom[off / 4];
    else                                 instr_i = 32'hDEADBEEF;
  end

  typedef struct {
    logic [31:0] pc, instr, pc4, fc, sc;
    logic        valid, fault;
  } exp_t;
  exp_t sb [$];

  // Behavioural model state
  longint unsigned m_pc;
  logic [31:0]     m_instr, m_pc4, m_fc, m_sc;
  logic            m_valid, m_fault;

  int tests = 0;
  int failed = 0;

  function automatic bit legal(input logic [31:0] a);
    longint unsigned x = a;
    return x >= BASE && x < longint'(BASE) + 4 * DEPTH && x % 4 == 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic rst, input logic st, input logic rd, input logic [31:0] tgt);
    if (rst) begin
      m_pc = BASE; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fault = 0; m_fc = 0; m_sc = 0;
    end else if (m_fault) begin
      m_valid = 0;
    end else if (rd) begin
      m_valid = 0;
      if (legal(tgt)) m_pc = tgt;
      else            m_fault = 1;
    end else if (st) begin
      if (m_valid && m_sc != 32'hFFFFFFFF) m_sc = m_sc + 1;
    end else begin
      m_instr = rom[(m_pc - BASE) / 4];
      m_pc4   = 32'(m_pc + 4);
      m_valid = 1;
      if (m_fc != 32'hFFFFFFFF) m_fc = m_fc + 1;
      if (legal(32'(m_pc + 4))) m_pc = m_pc + 4;
      else                      m_fault = 1;
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] tgt);
    exp_t e;
    @(negedge clk_i);
    reset_i = rst; stall_i = st; redirect_i = rd; target_i = tgt;
    model(rst, st, rd, tgt);
    e.pc = 32'(m_pc); e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    e.fault = m_fault; e.fc = m_fc; e.sc = m_sc;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] rand_target();
    int r = $urandom_range(0, 9);
    if (r < 7)  return BASE + 4 * $urandom_range(0, DEPTH - 1);
    if (r == 7) return BASE + $urandom_range(0, 4 * DEPTH - 1);
    if (r == 8) return BASE + 4 * DEPTH;
    return $urandom;
  endfunction

  // Monitor: compare every post-edge output set against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_o", pc_o, e.pc);
        chk("instr_o", instr_o, e.instr);
        chk("pc_plus4_o", pc_plus4_o, e.pc4);
        chk("valid_o", {31'b0, valid_o}, {31'b0, e.valid});
        chk("fault_o", {31'b0, fault_o}, {31'b0, e.fault});
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count_o", fetch_count_o, e.fc);
        chk("stall_count_o", stall_count_o, e.sc);
`endif
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;

    // Reset for three cycles, then fetch ROM[0], ROM[1]
    repeat (3) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Stall at pc 0x00400008, then release
    repeat (3) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    // Redirect beats stall
    step(0, 1, 1, 32'h00400020);
    step(0, 0, 0, 0);
    // Misaligned redirect faults; fault ignores stall/redirect
    step(0, 0, 1, 32'h00400022);
    for (int i = 0; i < 10; i++) step(0, 1'($urandom), 1'($urandom), rand_target());
    // Last word of the ROM, then advance past the end
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'h004000FC);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Data-segment target faults
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'h10010000);
    step(0, 0, 0, 0);
    // Five advances, two stalls, then reset mid-stall
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, rand_target());
    step(0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk_i);
    @(negedge clk_i);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
